// File: rtl/sap1_run_control.sv
// SAP-1 run control: loads program RAM over a valid/ready port,
// then gates the processor clock in run, step and pause modes.
module sap1_run_control #(
  parameter int          ADDR_W = 4,
  parameter int          DATA_W = 8,
  parameter logic [3:0]  HLT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic [3:0]        op_code,
  input  logic [5:0]        t_state,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_clr_n,
  output logic              cpu_ce,
  output logic              halted,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READY,
    S_RUN,
    S_STEP,
    S_HALTED
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic                r_armed;
  logic                w_armed;
  logic                r_stop_pend;
  logic                w_stop_pend;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count;
  logic                w_take;
  logic                w_exec;
  logic                w_bound;
  logic                w_hlt;
  logic                w_t6;

  // Clock gate: freeze the processor once it is back in T1 after an armed boundary.
  always_comb begin
    w_exec  = (r_state == S_RUN) || (r_state == S_STEP);
    w_bound = r_armed && (t_state == 6'd1);
    cpu_ce  = w_exec && !w_bound;
    w_hlt   = cpu_ce && (t_state == 6'd8) && (op_code == HLT_OP);
    w_t6    = cpu_ce && (t_state == 6'd32);
  end

  // Moore-style outputs decoded from the state and capture registers.
  always_comb begin
    host_ready = clr && (r_state == S_IDLE);
    ram_we     = (r_state == S_WRITE);
    ram_addr   = r_addr;
    ram_wdata  = r_data;
    cpu_clr_n  = (r_state != S_IDLE) && (r_state != S_WRITE);
    halted     = (r_state == S_HALTED);
    load_count = r_count;
  end

  // Next state, boundary arming and load counter.
  always_comb begin
    w_next      = r_state;
    w_armed     = r_armed;
    w_stop_pend = r_stop_pend;
    w_count     = r_count;
    w_take      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (host_valid) begin
          w_take = 1'b1;
          w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_count != CNT_MAX) w_count = r_count + 1'b1;
        w_next = r_last ? S_READY : S_IDLE;
      end
      S_READY: begin
        if (start) begin
          w_next = S_RUN;
        end else if (step) begin
          w_next = S_STEP;
        end else if (stop) begin
          w_next  = S_IDLE;
          w_count = '0;
        end
      end
      S_RUN, S_STEP: begin
        if (w_hlt) begin
          w_next      = S_HALTED;
          w_armed     = 1'b0;
          w_stop_pend = 1'b0;
        end else if (w_bound) begin
          w_next      = S_READY;
          w_armed     = 1'b0;
          w_stop_pend = 1'b0;
        end else begin
          if (r_state == S_RUN && stop) w_stop_pend = 1'b1;
          if (w_t6 && (r_state == S_STEP || r_stop_pend))
            w_armed = 1'b1;
        end
      end
      S_HALTED: begin
        if (stop) begin
          w_next  = S_IDLE;
          w_count = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_stop_pend <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_armed     <= w_armed;
      r_stop_pend <= w_stop_pend;
      r_count     <= w_count;
    end
  end

  // Capture the offered word on a host transfer.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_addr <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_take) begin
      r_addr <= host_addr;
      r_data <= host_data;
      r_last <= host_last;
    end
  end

endmodule

// File: doc/sap1_run_control.md
Name: sap1_run_control

Overview:
Run-control and program-loader sequencer for the SAP-1 processor. It loads a program into the 16x8 RAM through a valid/ready host port, holding the processor in clear while it loads. It then releases the processor and gates its clock enable in three modes: free-running, single-instruction step, and pause at an instruction boundary. It also detects HLT and parks the processor.

Parameters:
ADDR_W, 4, RAM address width; capacity 2^ADDR_W words
DATA_W, 8, RAM word width
HLT_OP, 4'hF, opcode that halts the processor

Ports:
clk  input  1  system clock; all state updates on posedge
clr  input  1  asynchronous, active-low reset
host_valid  input  1  host offers a program word
host_ready  output  1  block accepts a word this cycle
host_addr  input  ADDR_W  RAM address of offered word
host_data  input  DATA_W  offered word
host_last  input  1  offered word is the last of the program
start  input  1  begin free-running execution
step  input  1  execute exactly one instruction
stop  input  1  pause at next instruction boundary / return to IDLE
op_code  input  4  instruction-register opcode from the processor
t_state  input  6  one-hot ring state from the controller (6'd1..6'd32)
ram_we  output  1  RAM write strobe
ram_addr  output  ADDR_W  RAM write address
ram_wdata  output  DATA_W  RAM write data
cpu_clr_n  output  1  active-low clear to the processor
cpu_ce  output  1  processor clock enable (combinational, see below)
halted  output  1  processor executed HLT
load_count  output  ADDR_W+1  words written since last IDLE entry, saturating at 2^ADDR_W

Behaviour:
- Reset (clr low, asynchronous):
  - state=IDLE, armed=0, stop_pend=0.
  - ram_we=0, ram_addr=0, ram_wdata=0, cpu_clr_n=0, halted=0, load_count=0.
  - host_ready=0 while clr low; cpu_ce=0.
- States: IDLE, WRITE, READY, RUN, STEP, HALTED.
- IDLE:
  - host_ready=1, cpu_clr_n=0.
  - A transfer occurs when host_valid&&host_ready at posedge. It registers addr/data and goes to WRITE.
- WRITE (exactly one cycle):
  - ram_we=1 with the captured addr/data; host_ready=0; load_count increments (saturating).
  - Next state is READY if the captured host_last=1, else IDLE.
  - Throughput is one word per 2 cycles.
- READY:
  - cpu_clr_n=1; cpu_ce=0; host_ready=0.
  - Priority: start → RUN, then step → STEP, then stop → IDLE (load_count cleared, cpu_clr_n=0 next cycle).
- RUN:
  - stop sets stop_pend.
  - armed is set at a posedge where cpu_ce && t_state==6'd32 && stop_pend.
- STEP:
  - armed is set at a posedge where cpu_ce && t_state==6'd32.
- cpu_ce:
  - cpu_ce = (state==RUN||state==STEP) && !(armed && t_state==6'd1).
  - It is dropped combinationally after the processor's negedge returns to T1, so T1 of the next instruction is never executed.
  - At that posedge: state → READY; armed and stop_pend cleared.
- HLT detection:
  - At a posedge in RUN/STEP with cpu_ce && t_state==6'd8 && op_code==HLT_OP, go to HALTED.
  - HALTED has priority over a same-cycle stop or armed boundary.
- HALTED:
  - halted=1, cpu_ce=0, cpu_clr_n=1 (processor frozen in T4).
  - stop → IDLE (halted=0, cpu_clr_n=0, load_count=0).
  - start and step are ignored.
- Ignored inputs:
  - start/step outside READY are ignored.
  - host_valid outside IDLE is ignored; host_ready stays 0.
- Reset mid-operation: reset during WRITE aborts the write (ram_we drops asynchronously). No partial state survives.

Test Plan:
- Load 3 words (addr 0:8'h09, 1:8'h1A, 2:8'hF0, last on addr 2) → ram_we pulses at cycles 2, 4, 6; host_ready low during each WRITE; load_count=3; READY with cpu_clr_n=1, cpu_ce=0.
- RUN program LDA 9 / HLT (word 9=8'h2A) → cpu_ce high; HALTED entered at posedge with t_state=6'd8 and op_code=4'hF; halted=1, cpu_ce=0; stop → IDLE, load_count=0.
- STEP from READY → cpu_ce high for exactly 6 ring states (1,2,4,8,16,32); cpu_ce drops once t_state returns to 6'd1; back in READY; repeat step twice → two instructions executed.
- RUN then stop asserted mid-instruction (t_state=6'd4) → execution continues to 6'd32, pauses at 6'd1; start resumes from the next instruction.
- Simultaneous start+step in READY → RUN. stop on the same posedge as the HLT detect → HALTED.
- clr pulsed low during WRITE and during RUN → all outputs at reset values immediately; a new load from addr 0 succeeds.
